// File: rtl/operand_issuer_if.sv
// Operand/result bundle between operand_issuer and its environment: upstream tuples,
// the four datapath channels, returned results and the downstream result port.
interface operand_issuer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int RES_DEPTH  = 8
);
    logic [DATA_WIDTH-1:0]            s_a_i, s_b_i, s_c_i, s_d_i;
    logic                             s_valid_i, s_ready_o;
    logic [DATA_WIDTH-1:0]            a_o, b_o, c_o, d_o;
    logic                             a_valid_o, b_valid_o, c_valid_o, d_valid_o;
    logic [DATA_WIDTH-1:0]            q_i;
    logic                             q_valid_i;
    logic [DATA_WIDTH-1:0]            r_q_o;
    logic                             r_valid_o, r_ready_i;
    logic [$clog2(RES_DEPTH+1)-1:0]   inflight_o;
    logic                             err_o;

    modport slave (
        input  s_a_i, s_b_i, s_c_i, s_d_i, s_valid_i, q_i, q_valid_i, r_ready_i,
        output s_ready_o, a_o, b_o, c_o, d_o, a_valid_o, b_valid_o, c_valid_o, d_valid_o,
               r_q_o, r_valid_o, inflight_o, err_o
    );

    modport master (
        output s_a_i, s_b_i, s_c_i, s_d_i, s_valid_i, q_i, q_valid_i, r_ready_i,
        input  s_ready_o, a_o, b_o, c_o, d_o, a_valid_o, b_valid_o, c_valid_o, d_valid_o,
               r_q_o, r_valid_o, inflight_o, err_o
    );
endinterface

// File: rtl/operand_issuer.sv
// Buffers operand tuples, issues them to the datapath under result credit, and
// collects the in-order results into a show-ahead FIFO for downstream.
module operand_issuer #(
    parameter int DATA_WIDTH = 16,
    parameter int OP_DEPTH   = 4,
    parameter int RES_DEPTH  = 8
) (
    input  logic clk_i,
    input  logic artsn_i,
    operand_issuer_if.slave bus
);
    localparam int OCW = $clog2(OP_DEPTH + 1);
    localparam int OPW = $clog2(OP_DEPTH);
    localparam int RCW = $clog2(RES_DEPTH + 1);
    localparam int RPW = $clog2(RES_DEPTH);

    typedef logic [3:0][DATA_WIDTH-1:0] tuple_t;

    tuple_t                op_mem [OP_DEPTH];
    logic [OPW-1:0]        op_wr, op_rd;
    logic [OCW-1:0]        op_count;
    logic [DATA_WIDTH-1:0] res_mem [RES_DEPTH];
    logic [RPW-1:0]        res_wr, res_rd;
    logic [RCW-1:0]        res_count;
    logic [RCW-1:0]        inflight;
    tuple_t                ops;
    logic                  vld, err;
    logic                  op_push, op_pop, res_push, res_pop, credit_ok;

    function automatic logic [OPW-1:0] op_inc(input logic [OPW-1:0] p);
        return (p == OPW'(OP_DEPTH - 1)) ? '0 : p + OPW'(1);
    endfunction

    function automatic logic [RPW-1:0] res_inc(input logic [RPW-1:0] p);
        return (p == RPW'(RES_DEPTH - 1)) ? '0 : p + RPW'(1);
    endfunction

    assign bus.s_ready_o = (op_count != OCW'(OP_DEPTH));
    assign op_push       = bus.s_valid_i && bus.s_ready_o;
    // Every issued tuple reserves a result slot until it is read downstream.
    assign credit_ok     = ((RCW+1)'(inflight) + (RCW+1)'(res_count)) < (RCW+1)'(RES_DEPTH);
    assign op_pop        = (op_count != '0) && credit_ok;
    assign res_push      = bus.q_valid_i && ((inflight != '0) || op_pop);
    assign res_pop       = (res_count != '0) && bus.r_ready_i;

    always_ff @(posedge clk_i) begin
        if (op_push)  op_mem[op_wr]   <= {bus.s_d_i, bus.s_c_i, bus.s_b_i, bus.s_a_i};
        if (res_push) res_mem[res_wr] <= bus.q_i;
    end

    always_ff @(posedge clk_i or negedge artsn_i) begin
        if (!artsn_i) begin
            op_wr     <= '0;
            op_rd     <= '0;
            op_count  <= '0;
            res_wr    <= '0;
            res_rd    <= '0;
            res_count <= '0;
            inflight  <= '0;
            ops       <= '0;
            vld       <= 1'b0;
            err       <= 1'b0;
        end else begin
            vld <= op_pop;
            if (op_push) op_wr <= op_inc(op_wr);
            if (op_pop) begin
                ops   <= op_mem[op_rd];
                op_rd <= op_inc(op_rd);
            end
            case ({op_push, op_pop})
                2'b10:   op_count <= op_count + OCW'(1);
                2'b01:   op_count <= op_count - OCW'(1);
                default: op_count <= op_count;
            endcase

            if (res_push) res_wr <= res_inc(res_wr);
            if (res_pop)  res_rd <= res_inc(res_rd);
            case ({res_push, res_pop})
                2'b10:   res_count <= res_count + RCW'(1);
                2'b01:   res_count <= res_count - RCW'(1);
                default: res_count <= res_count;
            endcase

            case ({op_pop, res_push})
                2'b10:   inflight <= inflight + RCW'(1);
                2'b01:   inflight <= inflight - RCW'(1);
                default: inflight <= inflight;
            endcase

            // A result with nothing outstanding is dropped and flagged until reset.
            if (bus.q_valid_i && !res_push) err <= 1'b1;
        end
    end

    assign bus.a_o        = ops[0];
    assign bus.b_o        = ops[1];
    assign bus.c_o        = ops[2];
    assign bus.d_o        = ops[3];
    assign bus.a_valid_o  = vld;
    assign bus.b_valid_o  = vld;
    assign bus.c_valid_o  = vld;
    assign bus.d_valid_o  = vld;
    assign bus.r_valid_o  = (res_count != '0);
    assign bus.r_q_o      = res_mem[res_rd];
    assign bus.inflight_o = inflight;
    assign bus.err_o      = err;
endmodule

// File: tb/tb_operand_issuer.sv
// Directed plus random bench for operand_issuer against a queue-based reference model.
module tb_operand_issuer;
    localparam int DW  = 16;
    localparam int OPD = 4;
    localparam int RSD = 8;

    typedef logic [3:0][DW-1:0] tup_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_issuer_if #(.DATA_WIDTH(DW), .RES_DEPTH(RSD)) bus ();

    operand_issuer #(.DATA_WIDTH(DW), .OP_DEPTH(OPD), .RES_DEPTH(RSD)) dut (
        .clk_i   (clk),
        .artsn_i (rst_n),
        .bus     (bus)
    );

    tup_t          m_opq[$];
    logic [DW-1:0] m_resq[$];
    int            m_infl;
    bit            m_err, m_vld, last_push;
    tup_t          m_out;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_opq.delete();
        m_resq.delete();
        m_infl = 0;
        m_err  = 0;
        m_vld  = 0;
        m_out  = '0;
    endtask

    // One clock edge of the reference: credit = RES_DEPTH - inflight - buffered results.
    task automatic model_edge();
        bit   push, issue, pop, cap;
        tup_t t;
        push  = bus.s_valid_i && (m_opq.size() < OPD);
        issue = (m_opq.size() > 0) && ((m_infl + m_resq.size()) < RSD);
        pop   = (m_resq.size() > 0) && bus.r_ready_i;
        cap   = bus.q_valid_i && ((m_infl > 0) || issue);
        m_vld = issue;
        if (issue) m_out = m_opq.pop_front();
        if (push) begin
            t[0] = bus.s_a_i; t[1] = bus.s_b_i; t[2] = bus.s_c_i; t[3] = bus.s_d_i;
            m_opq.push_back(t);
        end
        if (pop) void'(m_resq.pop_front());
        if (cap) m_resq.push_back(bus.q_i);
        else if (bus.q_valid_i) m_err = 1;
        m_infl    = m_infl + int'(issue) - int'(cap);
        last_push = push;
    endtask

    task automatic check_all();
        check("s_ready", bus.s_ready_o, m_opq.size() < OPD);
        check("a_valid", bus.a_valid_o, m_vld);
        check("b_valid", bus.b_valid_o, m_vld);
        check("c_valid", bus.c_valid_o, m_vld);
        check("d_valid", bus.d_valid_o, m_vld);
        check("operands", {bus.d_o, bus.c_o, bus.b_o, bus.a_o}, m_out);
        check("r_valid", bus.r_valid_o, m_resq.size() > 0);
        if (m_resq.size() > 0) check("r_q", bus.r_q_o, m_resq[0]);
        check("inflight", bus.inflight_o, m_infl);
        check("err", bus.err_o, m_err);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        bus.s_valid_i = 0; bus.q_valid_i = 0; bus.r_ready_i = 0;
        bus.s_a_i = '0; bus.s_b_i = '0; bus.s_c_i = '0; bus.s_d_i = '0; bus.q_i = '0;
    endtask

    task automatic set_tuple(input int base);
        bus.s_a_i = DW'(base); bus.s_b_i = DW'(base + 1);
        bus.s_c_i = DW'(base + 2); bus.s_d_i = DW'(base + 3);
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        check("rst_infl", bus.inflight_o, 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int issues, pushed, n;
        idle();
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1;
        repeat (2) cycle();
        check("idle_ready", bus.s_ready_o, 1);

        // Single tuple
        bus.s_a_i = 10; bus.s_b_i = 4; bus.s_c_i = 2; bus.s_d_i = 1; bus.s_valid_i = 1;
        cycle();
        bus.s_valid_i = 0;
        check("single_pre_vld", bus.a_valid_o, 0);
        cycle();
        check("single_vld", bus.d_valid_o, 1);
        check("single_ops", {bus.a_o, bus.b_o, bus.c_o, bus.d_o}, {16'd10, 16'd4, 16'd2, 16'd1});
        cycle();
        check("single_vld_drop", bus.a_valid_o, 0);
        bus.q_i = 17; bus.q_valid_i = 1;
        cycle();
        bus.q_valid_i = 0;
        check("single_res", {bus.r_valid_o, bus.r_q_o}, {1'b1, 16'd17});
        check("single_infl", bus.inflight_o, 0);
        bus.r_ready_i = 1;
        cycle();
        bus.r_ready_i = 0;

        // Ordering and back-to-back issue
        issues = 0;
        for (int i = 0; i < 4; i++) begin
            set_tuple(16 * i); bus.s_valid_i = 1;
            cycle();
            if (bus.a_valid_o) issues++;
        end
        bus.s_valid_i = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            if (bus.a_valid_o) issues++;
        end
        check("b2b_issues", issues, 4);
        for (int i = 0; i < 4; i++) begin
            bus.q_i = DW'(100 + i); bus.q_valid_i = 1;
            cycle();
            bus.q_valid_i = 0;
            repeat (2) cycle();
        end
        bus.r_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            check("order_rq", bus.r_q_o, 100 + i);
            cycle();
        end
        bus.r_ready_i = 0;

        // Credit stall
        issues = 0; pushed = 0;
        for (int i = 0; i < 30; i++) begin
            bus.s_valid_i = (pushed < 12);
            set_tuple(1000 + 4 * pushed);
            cycle();
            if (last_push) pushed++;
            if (bus.a_valid_o) issues++;
        end
        bus.s_valid_i = 0;
        check("stall_issues", issues, 8);
        check("stall_ready", bus.s_ready_o, 0);
        bus.r_ready_i = 1;
        for (int i = 0; i < 60 && (m_infl > 0 || m_opq.size() > 0 || m_resq.size() > 0); i++) begin
            bus.q_valid_i = (m_infl > 0);
            bus.q_i = DW'($urandom);
            cycle();
            if (bus.a_valid_o) issues++;
        end
        bus.q_valid_i = 0;
        check("resume_issues", issues, 12);

        // Simultaneous issue and return at inflight 3
        for (int i = 0; i < 3; i++) begin
            set_tuple(2000 + 4 * i); bus.s_valid_i = 1;
            cycle();
        end
        bus.s_valid_i = 0;
        cycle();
        check("infl3", bus.inflight_o, 3);
        set_tuple(3000); bus.s_valid_i = 1;
        cycle();
        bus.s_valid_i = 0; bus.q_i = 16'h5a5a; bus.q_valid_i = 1;
        cycle();
        check("iss_ret_vld", bus.a_valid_o, 1);
        check("iss_ret_infl", bus.inflight_o, 3);
        for (int i = 0; i < 3; i++) begin
            bus.q_i = DW'(16'h600 + i);
            cycle();
        end
        bus.q_valid_i = 0;
        repeat (3) cycle();

        // Result push and pop together at res_count 7
        bus.r_ready_i = 0;
        for (int i = 0; i < 8; i++) begin
            set_tuple(4000 + 4 * i); bus.s_valid_i = 1;
            cycle();
        end
        bus.s_valid_i = 0;
        cycle();
        for (int i = 0; i < 7; i++) begin
            bus.q_i = DW'(16'h700 + i); bus.q_valid_i = 1;
            cycle();
        end
        bus.q_i = 16'h7ff; bus.r_ready_i = 1;
        cycle();
        bus.q_valid_i = 0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.r_valid_o) n++;
            cycle();
        end
        check("res7_count", n, 7);
        bus.r_ready_i = 0;

        // Spurious result
        bus.q_i = 16'hdead; bus.q_valid_i = 1;
        cycle();
        bus.q_valid_i = 0;
        check("spur_err", bus.err_o, 1);
        check("spur_res", bus.r_valid_o, 0);
        check("spur_infl", bus.inflight_o, 0);
        repeat (3) cycle();
        check("spur_sticky", bus.err_o, 1);

        // Reset mid-operation with buffered work
        for (int i = 0; i < 3; i++) begin
            set_tuple(5000 + 4 * i); bus.s_valid_i = 1;
            cycle();
        end
        idle();
        do_reset();
        check("rst_err", bus.err_o, 0);
        cycle();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            bus.s_valid_i = 1'($urandom_range(0, 1));
            bus.s_a_i = DW'($urandom); bus.s_b_i = DW'($urandom);
            bus.s_c_i = DW'($urandom); bus.s_d_i = DW'($urandom);
            bus.r_ready_i = ($urandom_range(0, 9) < 6);
            bus.q_valid_i = (m_infl > 0) && ($urandom_range(0, 2) != 0);
            bus.q_i = DW'($urandom);
            cycle();
        end
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/operand_issuer.md
Name: operand_issuer

Overview:
- Transmit-side counterpart of the four-channel operand interface used by the arithmetic datapath (a/b/c/d data with per-channel valid, q result with q_valid).
- Accepts packed operand tuples from upstream over valid/ready, buffers them, and drives all four channels with the valids asserted together.
- Captures the returned q results into a result FIFO and presents them downstream over valid/ready.
- Issue is gated by credit, so a result returned by the datapath, which has no backpressure, is never dropped.

Parameters:
- DATA_WIDTH, 16, width of each operand and of the result.
- OP_DEPTH, 4, operand FIFO depth in tuples (>=2).
- RES_DEPTH, 8, result FIFO depth. Also the limit on in-flight plus buffered results (>=2).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- artsn_i  in  1  reset, asynchronous, active-low.
- s_a_i, s_b_i, s_c_i, s_d_i  in  DATA_WIDTH each  upstream operand tuple.
- s_valid_i  in  1  upstream tuple valid.
- s_ready_o  out  1  operand FIFO can accept.
- a_o, b_o, c_o, d_o  out  DATA_WIDTH each  operands to datapath.
- a_valid_o, b_valid_o, c_valid_o, d_valid_o  out  1 each  operand valids; always equal to each other.
- q_i  in  DATA_WIDTH  result from datapath.
- q_valid_i  in  1  result valid.
- r_q_o  out  DATA_WIDTH  result to downstream (show-ahead head of result FIFO).
- r_valid_o  out  1  result FIFO not empty.
- r_ready_i  in  1  downstream accepts result.
- inflight_o  out  $clog2(RES_DEPTH+1)  tuples issued but not yet returned.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (artsn_i low, async): FIFOs emptied, in-flight counter 0, all valids 0, a_o..d_o 0, err_o 0, r_valid_o 0. s_ready_o is combinational !op_full, so it reads 1 after reset.
- Reset mid-operation discards all buffered operands and results and zeroes the in-flight count. The datapath shares the same reset.
- Operand write: on each rising edge where s_valid_i && s_ready_o, push the tuple. s_ready_o = 0 only when the FIFO holds OP_DEPTH entries; in that state a push and a pop in the same cycle are not accepted.
- Credit: credit = RES_DEPTH - inflight - res_count, computed from registered state.
- Issue: at a rising edge where op FIFO is not empty and credit > 0:
  - pop the head and register it onto a_o..d_o;
  - set all four valids to 1 for exactly one cycle;
  - inflight increments.
- No issue: all four valids are 0 and a_o..d_o hold their last value. At most one tuple is issued per cycle; back-to-back issue is allowed.
- Latency: a tuple accepted at edge N into an empty FIFO, with credit available, is driven with valids high from edge N+1. There is no bypass of the FIFO.
- Ordering is strict FIFO. The datapath returns results in order, so results are not tagged.
- Result capture: at an edge with q_valid_i = 1 and (inflight > 0 or an issue in the same cycle), push q_i into the result FIFO and decrement inflight.
  - Issue and return in the same cycle: inflight unchanged.
  - Overflow is impossible by the credit rule.
- Spurious result: q_valid_i = 1 with inflight = 0 and no issue in that cycle. The result is dropped, err_o is set and stays 1 until reset, and inflight does not underflow.
- Result read:
  - r_valid_o = !res_empty; r_q_o = head.
  - Pop when r_valid_o && r_ready_i.
  - Push and pop in the same cycle are both performed, including when res_count = RES_DEPTH - 1.
  - r_q_o is stable while r_valid_o && !r_ready_i.
- Stall: downstream holding r_ready_i = 0 fills the result FIFO. Issue then stops once inflight + res_count = RES_DEPTH. The operand FIFO fills next, and s_ready_o drops after OP_DEPTH further accepts.
- Pointers wrap modulo depth. Full/empty come from occupancy counters, so non-power-of-two depths are legal.

Test Plan:
- Reset then idle: artsn_i pulsed low mid-cycle -> immediately valids 0, r_valid_o 0, inflight_o 0, err_o 0; s_ready_o 1 after release.
- Single tuple: push a=10, b=4, c=2, d=1 at edge N -> a_o..d_o = 10, 4, 2, 1 with all valids high only in the cycle after edge N. Return q_i=17 -> r_valid_o 1, r_q_o 17, inflight_o back to 0.
- Ordering and back-to-back: push 4 tuples on consecutive edges -> valids high 4 consecutive cycles in push order. Results 100, 101, 102, 103 returned with gaps -> read out in the same order.
- Credit stall, RES_DEPTH=8, r_ready_i=0, 12 tuples pushed, no q returned:
  - exactly 8 issues, then valids stay 0;
  - s_ready_o falls after the operand FIFO holds 4;
  - raising r_ready_i plus returning results resumes issue one tuple per freed credit.
- Simultaneous issue and return with inflight=3 -> inflight_o stays 3. Simultaneous result push and pop at res_count=7 -> count stays 7 and data order is preserved.
- Spurious q_valid_i with inflight 0 -> err_o 1 permanently, result FIFO unchanged, inflight_o 0. err_o clears only on reset.
